// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand bank: FSM states, operator
// codes and a sign-magnitude helper.
package calc_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] ADD = 2'd0;
  localparam logic [OP_W-1:0] SUB = 2'd1;
  localparam logic [OP_W-1:0] MUL = 2'd2;
  localparam logic [OP_W-1:0] DIV = 2'd3;

  typedef enum logic [1:0] {
    ENTRY,
    AFTER_OP,
    AFTER_EQ,
    ERROR
  } state_t;

  // A zero magnitude always carries a positive sign, so -0 never appears.
  function automatic logic sm_sign(input logic sign, input logic mag_nonzero);
    return sign & mag_nonzero;
  endfunction

endpackage

// File: rtl/calc_entry_shifter.sv
// Magnitude and digit counter of the operand being entered; the FSM drives
// mutually exclusive clear/load/shift/backspace controls.
module calc_entry_shifter #(
  parameter int DIGITS = 4,
  parameter int MAG_W  = 4 * DIGITS,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_value,
  input  logic [MAG_W-1:0] value,
  input  logic             load_digit,
  input  logic             shift,
  input  logic             backsp,
  input  logic [3:0]       hexcode,
  output logic [MAG_W-1:0] mag,
  output logic [MAG_W-1:0] mag_next,
  output logic [CW-1:0]    digit_count,
  output logic             entry_full
);

  logic [CW-1:0] count_next;

  // mag_next is exposed so the sign can be normalised in the same cycle.
  always_comb begin
    mag_next   = mag;
    count_next = digit_count;
    if (clear) begin
      mag_next   = '0;
      count_next = '0;
    end else if (load_value) begin
      mag_next   = value;
      count_next = '0;
    end else if (load_digit) begin
      mag_next   = {{(MAG_W-4){1'b0}}, hexcode};
      count_next = (hexcode != 4'h0) ? CW'(1) : '0;
    end else if (shift) begin
      if ((digit_count < CW'(DIGITS)) && !((digit_count == '0) && (hexcode == 4'h0))) begin
        mag_next   = {mag[MAG_W-5:0], hexcode};
        count_next = digit_count + CW'(1);
      end
    end else if (backsp) begin
      mag_next = mag >> 4;
      if (digit_count != '0) count_next = digit_count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mag         <= '0;
      digit_count <= '0;
    end else begin
      mag         <= mag_next;
      digit_count <= count_next;
    end
  end

  assign entry_full = (digit_count == CW'(DIGITS));

endmodule

// File: rtl/calc_operand_bank.sv
// Two-operand register block of the calculator: entry operand v1, stored
// operand v2, latched operator, chaining and a sticky error state.
module calc_operand_bank #(
  parameter int DIGITS = 4,
  parameter int OP_W   = calc_pkg::OP_W,
  parameter int MAG_W  = 4 * DIGITS,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            newhex,
  input  logic [3:0]      hexcode,
  input  logic            newop,
  input  logic [OP_W-1:0] opcode,
  input  logic            eq,
  input  logic            bs,
  input  logic            neg,
  input  logic            ce,
  input  logic            clr,
  input  logic [MAG_W:0]  answer,
  input  logic            answer_ovf,
  output logic [MAG_W:0]  v1,
  output logic [MAG_W:0]  v2,
  output logic [OP_W-1:0] op_q,
  output logic            pending_op,
  output logic [CW-1:0]   digit_count,
  output logic            entry_full,
  output logic            err
);
  import calc_pkg::*;

  state_t           state;
  logic             sign, sign_d;
  logic [MAG_W-1:0] mag, mag_next;
  logic             live, in_entry, chain_ok;
  logic             ev_eq, ev_op, ev_ce, ev_hex, ev_bs, ev_neg;
  logic             sh_clear, sh_load_value, sh_load_digit, sh_shift, sh_bs;
  logic [MAG_W:0]   answer_norm;

  // Only the highest-priority event of the cycle survives; ERROR mutes all but clr.
  always_comb begin
    live     = (state != ERROR) && !clr;
    in_entry = (state == ENTRY);
    chain_ok = pending_op && !answer_ovf;
    ev_eq    = live && eq;
    ev_op    = live && !eq && newop;
    ev_ce    = live && !eq && !newop && ce;
    ev_hex   = live && !eq && !newop && !ce && newhex;
    ev_bs    = live && !eq && !newop && !ce && !newhex && bs;
    ev_neg   = live && !eq && !newop && !ce && !newhex && !bs && neg;

    sh_clear      = clr || ev_ce;
    sh_load_value = (ev_eq && chain_ok) || (ev_op && in_entry && chain_ok);
    sh_load_digit = ev_hex && !in_entry;
    sh_shift      = ev_hex && in_entry;
    sh_bs         = ev_bs && in_entry;

    sign_d = sign;
    if (sh_clear || sh_load_digit) sign_d = 1'b0;
    else if (sh_load_value)        sign_d = answer[MAG_W];
    else if (ev_neg)               sign_d = !sign;

    answer_norm = {sm_sign(answer[MAG_W], |answer[MAG_W-1:0]), answer[MAG_W-1:0]};
  end

  calc_entry_shifter #(
    .DIGITS(DIGITS),
    .MAG_W (MAG_W),
    .CW    (CW)
  ) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .clear      (sh_clear),
    .load_value (sh_load_value),
    .value      (answer[MAG_W-1:0]),
    .load_digit (sh_load_digit),
    .shift      (sh_shift),
    .backsp     (sh_bs),
    .hexcode    (hexcode),
    .mag        (mag),
    .mag_next   (mag_next),
    .digit_count(digit_count),
    .entry_full (entry_full)
  );

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      state      <= ENTRY;
      sign       <= 1'b0;
      v2         <= '0;
      op_q       <= '0;
      pending_op <= 1'b0;
      err        <= 1'b0;
    end else if (state != ERROR) begin
      sign <= sm_sign(sign_d, |mag_next);
      if (ev_eq) begin
        if (pending_op && answer_ovf) begin
          state <= ERROR;
          err   <= 1'b1;
        end else begin
          pending_op <= 1'b0;
          state      <= AFTER_EQ;
        end
      end else if (ev_op) begin
        case (state)
          ENTRY: begin
            if (!pending_op) begin
              v2         <= v1;
              op_q       <= opcode;
              pending_op <= 1'b1;
              state      <= AFTER_OP;
            end else if (answer_ovf) begin
              state <= ERROR;
              err   <= 1'b1;
            end else begin
              v2    <= answer_norm;
              op_q  <= opcode;
              state <= AFTER_OP;
            end
          end
          AFTER_OP: op_q <= opcode;
          default: begin
            v2         <= v1;
            op_q       <= opcode;
            pending_op <= 1'b1;
            state      <= AFTER_OP;
          end
        endcase
      end else if (ev_ce || ev_hex) begin
        state <= ENTRY;
      end
    end
  end

  assign v1 = {sign, mag};

endmodule

// File: tb/tb_calc_operand_bank.sv
// Directed, table-driven bench for calc_operand_bank with DIGITS=4.
module tb_calc_operand_bank;
  import calc_pkg::*;

  typedef enum logic [2:0] {K_NONE, K_HEX, K_OP, K_EQ, K_BS, K_NEG, K_CE, K_CLR} key_t;

  typedef struct {
    key_t        key;
    logic [3:0]  arg;
    logic [16:0] ans;
    logic        ovf;
    logic [16:0] e_v1;
    logic [16:0] e_v2;
    logic [1:0]  e_op;
    logic        e_pend;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        newhex = 1'b0, newop = 1'b0, eq = 1'b0, bs = 1'b0;
  logic        neg = 1'b0, ce = 1'b0, clr = 1'b0, answer_ovf = 1'b0;
  logic [3:0]  hexcode = 4'h0;
  logic [1:0]  opcode = 2'd0;
  logic [16:0] answer = 17'h0;
  logic [16:0] v1, v2;
  logic [1:0]  op_q;
  logic        pending_op, entry_full, err;
  logic [2:0]  digit_count;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  calc_operand_bank #(.DIGITS(4), .OP_W(2)) dut (
    .clock(clock), .reset(reset), .newhex(newhex), .hexcode(hexcode),
    .newop(newop), .opcode(opcode), .eq(eq), .bs(bs), .neg(neg), .ce(ce),
    .clr(clr), .answer(answer), .answer_ovf(answer_ovf), .v1(v1), .v2(v2),
    .op_q(op_q), .pending_op(pending_op), .digit_count(digit_count),
    .entry_full(entry_full), .err(err)
  );

  always #5 clock = ~clock;

  task automatic add(input key_t k, input logic [3:0] a, input logic [16:0] an, input logic o,
                     input logic [16:0] ev1, input logic [16:0] ev2, input logic [1:0] eop,
                     input logic ep, input logic [2:0] ec, input logic ee);
    vec_t v;
    v.key = k; v.arg = a; v.ans = an; v.ovf = o;
    v.e_v1 = ev1; v.e_v2 = ev2; v.e_op = eop; v.e_pend = ep; v.e_cnt = ec; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [16:0] ev1, input logic [16:0] ev2,
                              input logic [1:0] eop, input logic ep, input logic [2:0] ec,
                              input logic ee);
    cmp({name, ".v1"}, v1, ev1);
    cmp({name, ".v2"}, v2, ev2);
    cmp({name, ".op_q"}, {15'd0, op_q}, {15'd0, eop});
    cmp({name, ".pending_op"}, {16'd0, pending_op}, {16'd0, ep});
    cmp({name, ".digit_count"}, {14'd0, digit_count}, {14'd0, ec});
    cmp({name, ".entry_full"}, {16'd0, entry_full}, {16'd0, (ec == 3'd4)});
    cmp({name, ".err"}, {16'd0, err}, {16'd0, ee});
  endtask

  task automatic apply_stimulus(input key_t k, input logic [3:0] a, input logic [16:0] an,
                                input logic o);
    @(negedge clock);
    hexcode = a; opcode = a[1:0]; answer = an; answer_ovf = o;
    newhex = (k == K_HEX); newop = (k == K_OP); eq = (k == K_EQ); bs = (k == K_BS);
    neg = (k == K_NEG); ce = (k == K_CE); clr = (k == K_CLR);
    @(posedge clock);
    #1;
    {newhex, newop, eq, bs, neg, ce, clr} = '0;
  endtask

  initial begin
    // Entry with leading zero and full-entry limit
    add(K_HEX, 4'h0, 17'h0, 0, 17'h00000, 17'h0, 0, 0, 0, 0);
    add(K_HEX, 4'h1, 17'h0, 0, 17'h00001, 17'h0, 0, 0, 1, 0);
    add(K_HEX, 4'h2, 17'h0, 0, 17'h00012, 17'h0, 0, 0, 2, 0);
    add(K_HEX, 4'h3, 17'h0, 0, 17'h00123, 17'h0, 0, 0, 3, 0);
    add(K_HEX, 4'h4, 17'h0, 0, 17'h01234, 17'h0, 0, 0, 4, 0);
    add(K_HEX, 4'h5, 17'h0, 0, 17'h01234, 17'h0, 0, 0, 4, 0);
    // Backspace and sign toggle, sign cleared at zero
    add(K_BS,  4'h0, 17'h0, 0, 17'h00123, 17'h0, 0, 0, 3, 0);
    add(K_BS,  4'h0, 17'h0, 0, 17'h00012, 17'h0, 0, 0, 2, 0);
    add(K_NEG, 4'h0, 17'h0, 0, 17'h10012, 17'h0, 0, 0, 2, 0);
    add(K_BS,  4'h0, 17'h0, 0, 17'h10001, 17'h0, 0, 0, 1, 0);
    add(K_BS,  4'h0, 17'h0, 0, 17'h00000, 17'h0, 0, 0, 0, 0);
    add(K_BS,  4'h0, 17'h0, 0, 17'h00000, 17'h0, 0, 0, 0, 0);
    add(K_NEG, 4'h0, 17'h0, 0, 17'h00000, 17'h0, 0, 0, 0, 0);
    // Operator latch and replacement
    add(K_HEX, 4'h1, 17'h0, 0, 17'h00001, 17'h0, 0, 0, 1, 0);
    add(K_HEX, 4'h2, 17'h0, 0, 17'h00012, 17'h0, 0, 0, 2, 0);
    add(K_OP,  MUL,  17'h0, 0, 17'h00012, 17'h00012, MUL, 1, 2, 0);
    add(K_OP,  SUB,  17'h0, 0, 17'h00012, 17'h00012, SUB, 1, 2, 0);
    add(K_HEX, 4'h3, 17'h0, 0, 17'h00003, 17'h00012, SUB, 1, 1, 0);
    // Equals, fresh entry, chained operation
    add(K_EQ,  4'h0, 17'h0000F, 0, 17'h0000F, 17'h00012, SUB, 0, 0, 0);
    add(K_HEX, 4'h7, 17'h0, 0, 17'h00007, 17'h00012, SUB, 0, 1, 0);
    add(K_OP,  ADD,  17'h0, 0, 17'h00007, 17'h00007, ADD, 1, 1, 0);
    add(K_HEX, 4'h2, 17'h0, 0, 17'h00002, 17'h00007, ADD, 1, 1, 0);
    add(K_OP,  DIV,  17'h10005, 0, 17'h10005, 17'h10005, DIV, 1, 0, 0);
    add(K_NEG, 4'h0, 17'h0, 0, 17'h00005, 17'h10005, DIV, 1, 0, 0);
    add(K_NEG, 4'h0, 17'h0, 0, 17'h10005, 17'h10005, DIV, 1, 0, 0);
    add(K_BS,  4'h0, 17'h0, 0, 17'h10005, 17'h10005, DIV, 1, 0, 0);
    add(K_HEX, 4'h0, 17'h0, 0, 17'h00000, 17'h10005, DIV, 1, 0, 0);
    add(K_HEX, 4'h9, 17'h0, 0, 17'h00009, 17'h10005, DIV, 1, 1, 0);
    // Error on equals, frozen until clr
    add(K_EQ,  4'h0, 17'h0, 1, 17'h00009, 17'h10005, DIV, 1, 1, 1);
    add(K_HEX, 4'h4, 17'h0, 0, 17'h00009, 17'h10005, DIV, 1, 1, 1);
    add(K_BS,  4'h0, 17'h0, 0, 17'h00009, 17'h10005, DIV, 1, 1, 1);
    add(K_EQ,  4'h0, 17'h00001, 0, 17'h00009, 17'h10005, DIV, 1, 1, 1);
    add(K_OP,  ADD,  17'h00001, 0, 17'h00009, 17'h10005, DIV, 1, 1, 1);
    add(K_CE,  4'h0, 17'h0, 0, 17'h00009, 17'h10005, DIV, 1, 1, 1);
    add(K_CLR, 4'h0, 17'h0, 0, 17'h00000, 17'h0, 0, 0, 0, 0);
    // Clear entry, equals without pending operator
    add(K_HEX, 4'h5, 17'h0, 0, 17'h00005, 17'h0, 0, 0, 1, 0);
    add(K_CE,  4'h0, 17'h0, 0, 17'h00000, 17'h0, 0, 0, 0, 0);
    add(K_EQ,  4'h0, 17'h00077, 0, 17'h00000, 17'h0, 0, 0, 0, 0);
    // Error on chained operator overflow
    add(K_HEX, 4'h3, 17'h0, 0, 17'h00003, 17'h0, 0, 0, 1, 0);
    add(K_OP,  ADD,  17'h0, 0, 17'h00003, 17'h00003, ADD, 1, 1, 0);
    add(K_HEX, 4'h4, 17'h0, 0, 17'h00004, 17'h00003, ADD, 1, 1, 0);
    add(K_OP,  SUB,  17'h00007, 1, 17'h00004, 17'h00003, ADD, 1, 1, 1);
    add(K_CLR, 4'h0, 17'h0, 0, 17'h00000, 17'h0, 0, 0, 0, 0);
    // Negative-zero answer is normalised
    add(K_HEX, 4'h6, 17'h0, 0, 17'h00006, 17'h0, 0, 0, 1, 0);
    add(K_OP,  SUB,  17'h0, 0, 17'h00006, 17'h00006, SUB, 1, 1, 0);
    add(K_HEX, 4'h6, 17'h0, 0, 17'h00006, 17'h00006, SUB, 1, 1, 0);
    add(K_EQ,  4'h0, 17'h10000, 0, 17'h00000, 17'h00006, SUB, 0, 0, 0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_output("reset", 17'h0, 17'h0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].key, vecs[i].arg, vecs[i].ans, vecs[i].ovf);
      check_output($sformatf("vec%0d", i), vecs[i].e_v1, vecs[i].e_v2, vecs[i].e_op,
                   vecs[i].e_pend, vecs[i].e_cnt, vecs[i].e_err);
    end

    // newhex and eq together: eq wins, so the next digit starts a fresh entry
    apply_stimulus(K_HEX, 4'h1, 17'h0, 0);
    apply_stimulus(K_HEX, 4'h2, 17'h0, 0);
    check_output("pre_tie", 17'h00012, 17'h00006, SUB, 0, 2, 0);
    @(negedge clock);
    newhex = 1'b1; hexcode = 4'h3; eq = 1'b1;
    @(posedge clock);
    #1;
    newhex = 1'b0; eq = 1'b0;
    check_output("tie_eq_hex", 17'h00012, 17'h00006, SUB, 0, 2, 0);
    apply_stimulus(K_HEX, 4'h4, 17'h0, 0);
    check_output("after_tie", 17'h00004, 17'h00006, SUB, 0, 1, 0);

    // Reset in the middle of an entry
    apply_stimulus(K_CE, 4'h0, 17'h0, 0);
    apply_stimulus(K_HEX, 4'h1, 17'h0, 0);
    apply_stimulus(K_HEX, 4'h2, 17'h0, 0);
    apply_stimulus(K_HEX, 4'h3, 17'h0, 0);
    check_output("mid_entry", 17'h00123, 17'h00006, SUB, 0, 3, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_output("mid_reset", 17'h0, 17'h0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_operand_bank.md
Name: calc_operand_bank

Overview:
- Parametrised successor to the calculator's two-operand register block.
- Holds the operand being entered (v1) and the stored operand (v2) in sign-magnitude form, with a configurable number of hex digits.
- Adds a digit counter with entry limit, sign toggle, clear-entry/all-clear, a latched operator, chained operations and a sticky error state.
- Sits between the keypad decoder and the external ALU/display. The ALU computes answer/answer_ovf combinationally from v2, v1 and op_q.

Parameters:
- DIGITS, 4, number of hex digits per operand. Magnitude width MAG_W = 4*DIGITS.
- OP_W, 2, width of operator code.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- newhex  in  1  one-cycle pulse, hex key pressed
- hexcode  in  4  value of hex key
- newop  in  1  one-cycle pulse, operator key pressed
- opcode  in  OP_W  operator code accompanying newop
- eq  in  1  one-cycle pulse, equals pressed
- bs  in  1  one-cycle pulse, backspace
- neg  in  1  one-cycle pulse, sign toggle
- ce  in  1  one-cycle pulse, clear entry
- clr  in  1  one-cycle pulse, all clear
- answer  in  MAG_W+1  ALU result; MSB is sign, rest is magnitude
- answer_ovf  in  1  ALU result exceeds MAG_W or is invalid (e.g. divide by zero)
- v1  out  MAG_W+1  current/display operand, sign-magnitude
- v2  out  MAG_W+1  stored operand, sign-magnitude
- op_q  out  OP_W  latched operator
- pending_op  out  1  an operator is latched and awaiting a second operand
- digit_count  out  $clog2(DIGITS+1)  significant digits entered in v1
- entry_full  out  1  digit_count == DIGITS
- err  out  1  block is in ERROR state

Behaviour:
- Reset and clr (any state) drive all outputs to 0: v1, v2, op_q, pending_op, digit_count, err. State becomes ENTRY.
- All outputs are registered. Each event updates outputs on the clock edge that samples it (1-cycle latency).
- Event priority within one cycle: reset > clr > eq > newop > ce > newhex > bs > neg. Only the highest-priority event takes effect; lower ones are dropped.
- States: ENTRY, AFTER_OP, AFTER_EQ, ERROR.
- ENTRY:
  - newhex with digit_count < DIGITS: v1 magnitude becomes {mag[MAG_W-5:0], hexcode}, digit_count increments.
  - Leading zero (digit_count == 0 and hexcode == 0): v1 and digit_count are unchanged.
  - newhex with digit_count == DIGITS: ignored.
  - bs: magnitude shifts right 4 bits; digit_count decrements (saturates at 0).
  - neg: toggles sign only if magnitude != 0.
  - Any result of zero magnitude clears the sign; negative zero never appears on v1.
  - ce: v1 = 0, digit_count = 0.
- newop in ENTRY:
  - pending_op = 0: v2 = v1, op_q = opcode, pending_op = 1, next state AFTER_OP.
  - pending_op = 1 (chaining) and answer_ovf = 1: next state ERROR.
  - pending_op = 1 and answer_ovf = 0: v1 = answer, v2 = answer, op_q = opcode, pending_op stays 1, next state AFTER_OP.
- newop in AFTER_OP: replaces op_q only. v1 and v2 unchanged.
- newop in AFTER_EQ: v2 = v1, op_q = opcode, pending_op = 1, next state AFTER_OP.
- eq:
  - pending_op = 1 and answer_ovf = 1: next state ERROR.
  - pending_op = 1 and answer_ovf = 0: v1 = answer (zero magnitude forces sign 0), pending_op = 0, digit_count = 0, next state AFTER_EQ. v2 is retained.
  - pending_op = 0: v1 unchanged, next state AFTER_EQ.
- AFTER_OP / AFTER_EQ:
  - newhex: v1 = {0, zero-extended hexcode}; digit_count = (hexcode != 0); next state ENTRY.
  - bs: ignored.
  - neg: toggles the sign of v1 (if magnitude != 0); state unchanged.
  - ce: v1 = 0, digit_count = 0, next state ENTRY.
- ERROR: err = 1. v1 and v2 are frozen. Every input except clr/reset is ignored.
- A new key pulse may arrive every cycle; there is no back-pressure.

Decomposition:
- Shared package calc_pkg contains:
  - state enum: ENTRY, AFTER_OP, AFTER_EQ, ERROR;
  - OP_W and opcode localparams: ADD = 0, SUB = 1, MUL = 2, DIV = 3;
  - sign-magnitude helper function that normalises negative zero.
- One natural sub-module: calc_entry_shifter. It holds the v1 digit shift, backspace, digit_count, leading-zero and full logic, and is driven by load/shift/bs/clear controls from the FSM.

Test Plan (DIGITS=4):
1. Reset; hex 0,1,2,3,4,5 → v1=0_0001 after key 1; final v1=0_1234, digit_count=4, entry_full=1; key 5 ignored.
2. From v1=0_1234: bs,bs → 0_0012, count 2; neg → 1_0012; bs,bs → 0_0000 with sign 0, count 0.
3. Enter 12; newop opcode=2 → v2=0_0012, op_q=2, pending_op=1, v1 still 0_0012. Newop opcode=1 → op_q=1, v2 unchanged. Hex 3 → v1=0_0003.
4. Eq with answer=0_000F → v1=0_000F, pending_op=0, v2=0_0012. Hex 7 → v1=0_0007, count 1. Chain: newop then hex 2, newop with answer=1_0005 → v1=v2=1_0005.
5. Eq with pending_op=1, answer_ovf=1 → err=1. Hex/bs/eq/newop ignored, v1/v2 frozen. Clr → all outputs 0.
6. newhex and eq in the same cycle → eq wins, digit dropped. Reset asserted mid-entry (v1=0_0123) → all outputs 0 next cycle.
